ttt_sequencer: RTL and testbench
================================

Name: ttt_sequencer

Overview:
- Controller that owns one ttt_processor instance and drives its enable, instruction, token and data inputs.
- Per timestep tick, runs the fixed four-step sequence: add good tokens, add bad tokens, tally, advance countdown.
- Between timesteps, arbitrates a host programming port (valid/ready) onto the same instruction bus and returns the processor's data_out as read data.
- Sits between the network/timestep generator and the processor.

Parameters:
NEW_TOKEN_BITS, 4, width of signed per-step token deltas
DATA_BITS, 8, programming data width
INSTRUCTION_BITS, 4, processor opcode width
TICK_PERIOD, 16, auto-tick period in cycles (used only with TTT_SEQ_AUTO_TICK_EN)

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
tick_in  in  1  request one timestep; single-cycle pulse
good_tokens_in  in  NEW_TOKEN_BITS  signed good delta, sampled with tick
bad_tokens_in  in  NEW_TOKEN_BITS  signed bad delta, sampled with tick
host_valid  in  1  host command valid
host_ready  out  1  host command accepted when valid&&ready
host_instr  in  INSTRUCTION_BITS  opcode to issue
host_data  in  DATA_BITS  write data
host_rvalid  out  1  one-cycle pulse: host_rdata valid
host_rdata  out  DATA_BITS  processor data_out captured for the command
proc_enable  out  1  to processor enable
proc_instruction  out  INSTRUCTION_BITS  to processor instruction
proc_good_tokens  out  NEW_TOKEN_BITS  to processor good_tokens_in
proc_bad_tokens  out  NEW_TOKEN_BITS  to processor bad_tokens_in
proc_data_in  out  DATA_BITS  to processor data_in
proc_data_out  in  DATA_BITS  from processor data_out
busy  out  1  state != IDLE or a tick is pending
timestep_done  out  1  one-cycle pulse after each ADVANCE step
tick_overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- States: IDLE, ADD_GOOD, ADD_BAD, TALLY, ADVANCE, HOST_ISSUE, HOST_READ. State is a flop; proc_* outputs decode from state and registers.
- Reset: state=IDLE; pending=0; all token and data registers 0; every output 0.
- proc_enable=1 only in ADD_GOOD, ADD_BAD, TALLY, ADVANCE and HOST_ISSUE. Opcodes in those states: 0x0, 0x1, 0x8, 0x9, host_instr_q.
- Outside those states: proc_instruction=0; proc_data_in and token outputs hold their last values.
- Tick capture: tick accepted in IDLE at cycle t latches cur_good/cur_bad. ADD_GOOD is at t+1, ADD_BAD t+2, TALLY t+3, ADVANCE t+4. timestep_done pulses at t+5.
- proc_good_tokens = cur_good; proc_bad_tokens = cur_bad during the sequence.
- Tick in any non-IDLE state with pending=0: set pending and latch deltas into pend_good/pend_bad.
- Tick with pending=1: drop it; tick_overrun pulses next cycle; pending data unchanged.
- Tick in ADVANCE while pending=0 also becomes pending.
- From ADVANCE or HOST_READ with pending=1: copy pend_* into cur_*, clear pending, go to ADD_GOOD directly (no IDLE cycle).
- A pending tick and a new tick in the same cycle: the new tick is pended, or overruns if pending is not freed that cycle.
- Priority in IDLE: tick over host.
- host_ready = (state==IDLE) && !tick && !pending.
- Host accept at cycle t: latch instr/data. HOST_ISSUE at t+1 with proc_data_in = host_data_q.
  - Opcodes 0/1 drive host_data_q[NEW_TOKEN_BITS-1:0] on proc_good_tokens/proc_bad_tokens.
  - Opcodes 8/9 are issued unchanged.
- HOST_READ at t+2: host_rdata <= proc_data_out. host_rvalid pulses at t+3; host_rdata holds until the next capture.
- No back-pressure on read data.
- Mid-operation reset aborts the sequence or host command: no timestep_done, no host_rvalid; pending cleared.

Optional Feature:
TTT_SEQ_AUTO_TICK_EN:
- Defined: a free-running counter (reset 0) counts 0..TICK_PERIOD-1 and raises an internal tick when it wraps to 0.
  - Effective tick = tick_in OR internal tick, with identical pend/overrun rules.
  - Both ticks in the same cycle count as one tick.
- Undefined: no counter; only tick_in starts timesteps; TICK_PERIOD unused.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0, host_ready=1, busy=0.
- Tick with good=+3, bad=-1 at cycle t:
  - proc_enable high t+1..t+4 with opcodes 0,1,8,9.
  - proc_good_tokens=4'h3 and proc_bad_tokens=4'hF throughout.
  - timestep_done at t+5.
- Host write 0xE data 0x05, then host read 0x7 -> host_rvalid 3 cycles after each accept; rdata 0x05 for the write; host_ready low while busy.
- Tick at t, second tick (+1,0) at t+2, third at t+3:
  - second sequence starts ADD_GOOD at t+5 with good=1.
  - tick_overrun pulses at t+4.
  - exactly two timestep_done pulses.
- host_valid and tick asserted together in IDLE -> tick wins, host_ready=0; host command issues after the timestep_done cycle.
- Reset asserted during TALLY -> next cycle IDLE, proc_enable=0, no timestep_done.
- With TTT_SEQ_AUTO_TICK_EN, TICK_PERIOD=16 -> timestep_done every 16 cycles; an extra tick_in mid-sequence is pended.

Source files
------------

// File: rtl/ttt_sequencer.sv
// Timestep sequencer in front of one ttt_processor: per tick it issues add-good, add-bad, tally, advance;
// between ticks it forwards host commands. Optional macro TTT_SEQ_AUTO_TICK_EN adds a free-running tick source.
//   state      | meaning
//   IDLE       | waiting for a tick (pending or new) or a host command
//   ADD_GOOD   | opcode 0x0 with cur_good on the token bus
//   ADD_BAD    | opcode 0x1 with cur_bad on the token bus
//   TALLY      | opcode 0x8
//   ADVANCE    | opcode 0x9; chains straight into a pending tick
//   HOST_ISSUE | host opcode driven with host_data_q
//   HOST_READ  | capture processor data_out for the host
module ttt_sequencer #(
  parameter int NEW_TOKEN_BITS   = 4,
  parameter int DATA_BITS        = 8,
  parameter int INSTRUCTION_BITS = 4,
  parameter int TICK_PERIOD      = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        tick_in,
  input  logic [NEW_TOKEN_BITS-1:0]   good_tokens_in,
  input  logic [NEW_TOKEN_BITS-1:0]   bad_tokens_in,
  input  logic                        host_valid,
  output logic                        host_ready,
  input  logic [INSTRUCTION_BITS-1:0] host_instr,
  input  logic [DATA_BITS-1:0]        host_data,
  output logic                        host_rvalid,
  output logic [DATA_BITS-1:0]        host_rdata,
  output logic                        proc_enable,
  output logic [INSTRUCTION_BITS-1:0] proc_instruction,
  output logic [NEW_TOKEN_BITS-1:0]   proc_good_tokens,
  output logic [NEW_TOKEN_BITS-1:0]   proc_bad_tokens,
  output logic [DATA_BITS-1:0]        proc_data_in,
  input  logic [DATA_BITS-1:0]        proc_data_out,
  output logic                        busy,
  output logic                        timestep_done,
  output logic                        tick_overrun
);

  typedef enum logic [2:0] {
    IDLE, ADD_GOOD, ADD_BAD, TALLY, ADVANCE, HOST_ISSUE, HOST_READ
  } state_t;

  state_t                        state, state_n;
  logic                          pending, pending_n;
  logic [NEW_TOKEN_BITS-1:0]     pend_good, pend_good_n, pend_bad, pend_bad_n;
  logic [NEW_TOKEN_BITS-1:0]     cur_good, cur_good_n, cur_bad, cur_bad_n;
  logic [INSTRUCTION_BITS-1:0]   host_instr_q, host_instr_n;
  logic [DATA_BITS-1:0]          host_data_q, host_data_n;
  logic                          overrun_n;
  logic                          free_slot;
  logic                          tick;

`ifdef TTT_SEQ_AUTO_TICK_EN
  localparam int CNT_BITS = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  logic [CNT_BITS-1:0] tick_cnt;
  logic                auto_tick;

  // auto_tick is high in the cycle the counter has just wrapped back to 0
  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt  <= '0;
      auto_tick <= 1'b0;
    end else begin
      tick_cnt  <= (tick_cnt == CNT_BITS'(TICK_PERIOD - 1)) ? '0 : tick_cnt + 1'b1;
      auto_tick <= (tick_cnt == CNT_BITS'(TICK_PERIOD - 1));
    end
  end

  assign tick = tick_in | auto_tick;
`else
  logic unused_tick_period;
  assign unused_tick_period = (TICK_PERIOD == 0);
  assign tick = tick_in;
`endif

  assign host_ready       = (state == IDLE) && !tick && !pending;
  assign busy             = (state != IDLE) || pending;
  assign proc_good_tokens = cur_good;
  assign proc_bad_tokens  = cur_bad;
  assign proc_data_in     = host_data_q;

  always_comb begin
    state_n          = state;
    pending_n        = pending;
    pend_good_n      = pend_good;
    pend_bad_n       = pend_bad;
    cur_good_n       = cur_good;
    cur_bad_n        = cur_bad;
    host_instr_n     = host_instr_q;
    host_data_n      = host_data_q;
    overrun_n        = 1'b0;
    proc_enable      = 1'b0;
    proc_instruction = '0;
    // the pending slot is handed to the sequence wherever the next step may start a timestep
    free_slot = pending && (state == IDLE || state == ADVANCE || state == HOST_READ);

    case (state)
      IDLE: begin
        if (pending) begin
          state_n    = ADD_GOOD;
          cur_good_n = pend_good;
          cur_bad_n  = pend_bad;
        end else if (tick) begin
          state_n    = ADD_GOOD;
          cur_good_n = good_tokens_in;
          cur_bad_n  = bad_tokens_in;
        end else if (host_valid) begin
          state_n      = HOST_ISSUE;
          host_instr_n = host_instr;
          host_data_n  = host_data;
          if (host_instr == INSTRUCTION_BITS'(0))
            cur_good_n = host_data[NEW_TOKEN_BITS-1:0];
          else if (host_instr == INSTRUCTION_BITS'(1))
            cur_bad_n = host_data[NEW_TOKEN_BITS-1:0];
        end
      end
      ADD_GOOD: begin
        proc_enable      = 1'b1;
        proc_instruction = INSTRUCTION_BITS'(0);
        state_n          = ADD_BAD;
      end
      ADD_BAD: begin
        proc_enable      = 1'b1;
        proc_instruction = INSTRUCTION_BITS'(1);
        state_n          = TALLY;
      end
      TALLY: begin
        proc_enable      = 1'b1;
        proc_instruction = INSTRUCTION_BITS'(8);
        state_n          = ADVANCE;
      end
      ADVANCE: begin
        proc_enable      = 1'b1;
        proc_instruction = INSTRUCTION_BITS'(9);
        state_n          = IDLE;
        if (pending) begin
          state_n    = ADD_GOOD;
          cur_good_n = pend_good;
          cur_bad_n  = pend_bad;
        end
      end
      HOST_ISSUE: begin
        proc_enable      = 1'b1;
        proc_instruction = host_instr_q;
        state_n          = HOST_READ;
      end
      HOST_READ: begin
        state_n = IDLE;
        if (pending) begin
          state_n    = ADD_GOOD;
          cur_good_n = pend_good;
          cur_bad_n  = pend_bad;
        end
      end
      default: state_n = IDLE;
    endcase

    if (tick && !(state == IDLE && !pending)) begin
      if (!pending || free_slot) begin
        pending_n   = 1'b1;
        pend_good_n = good_tokens_in;
        pend_bad_n  = bad_tokens_in;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (free_slot) begin
      pending_n = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      pending       <= 1'b0;
      pend_good     <= '0;
      pend_bad      <= '0;
      cur_good      <= '0;
      cur_bad       <= '0;
      host_instr_q  <= '0;
      host_data_q   <= '0;
      host_rdata    <= '0;
      host_rvalid   <= 1'b0;
      timestep_done <= 1'b0;
      tick_overrun  <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      pend_good     <= pend_good_n;
      pend_bad      <= pend_bad_n;
      cur_good      <= cur_good_n;
      cur_bad       <= cur_bad_n;
      host_instr_q  <= host_instr_n;
      host_data_q   <= host_data_n;
      host_rvalid   <= (state == HOST_READ);
      timestep_done <= (state == ADVANCE);
      tick_overrun  <= overrun_n;
      if (state == HOST_READ)
        host_rdata <= proc_data_out;
    end
  end

endmodule

// File: tb/tb_ttt_sequencer.sv
// Bench for ttt_sequencer: schedule-based reference model checked every cycle, directed scenarios
// with literal expectations, then randomized ticks, host commands and resets.
module tb_ttt_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       tick_in;
  logic [3:0] good_tokens_in, bad_tokens_in;
  logic       host_valid;
  logic       host_ready;
  logic [3:0] host_instr;
  logic [7:0] host_data;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       proc_enable;
  logic [3:0] proc_instruction;
  logic [3:0] proc_good_tokens, proc_bad_tokens;
  logic [7:0] proc_data_in;
  logic [7:0] proc_data_out;
  logic       busy, timestep_done, tick_overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int done_cnt = 0;

  ttt_sequencer dut (
    .clock(clock), .reset(reset), .tick_in(tick_in),
    .good_tokens_in(good_tokens_in), .bad_tokens_in(bad_tokens_in),
    .host_valid(host_valid), .host_ready(host_ready), .host_instr(host_instr),
    .host_data(host_data), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .proc_enable(proc_enable), .proc_instruction(proc_instruction),
    .proc_good_tokens(proc_good_tokens), .proc_bad_tokens(proc_bad_tokens),
    .proc_data_in(proc_data_in), .proc_data_out(proc_data_out),
    .busy(busy), .timestep_done(timestep_done), .tick_overrun(tick_overrun)
  );

  always #5 clock = ~clock;

  // stand-in processor: opcode 0xE stores data_in, any other enabled opcode increments
  logic [7:0] preg;
  assign proc_data_out = preg;
  always @(posedge clock) begin
    if (reset) preg <= 8'h00;
    else if (proc_enable) preg <= (proc_instruction == 4'hE) ? proc_data_in : preg + 8'h01;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model: operations are scheduled as future-cycle expectations in a ring
  bit         armed = 0;
  int         last_op = -1;
  int         rd_cycle = -1;
  int         auto_n = 0;
  bit         pend = 0;
  logic [3:0] pg, pb;
  bit         r_en[8], r_done[8], r_over[8], r_rv[8];
  logic [3:0] r_op[8];
  logic [3:0] m_good, m_bad;
  logic [7:0] m_din, m_rdata;
  logic [3:0] seq_ops[4] = '{4'h0, 4'h1, 4'h8, 4'h9};

  task automatic start_seq(input int s, input logic [3:0] g, input logic [3:0] b);
    for (int k = 0; k < 4; k++) begin
      r_en[(s + k) % 8] = 1;
      r_op[(s + k) % 8] = seq_ops[k];
    end
    r_done[(s + 4) % 8] = 1;
    last_op = s + 3;
    m_good = g;
    m_bad  = b;
  endtask

  task automatic start_host(input int s);
    r_en[s % 8] = 1;
    r_op[s % 8] = host_instr;
    m_din = host_data;
    if (host_instr == 4'h0) m_good = host_data[3:0];
    if (host_instr == 4'h1) m_bad  = host_data[3:0];
    last_op  = s + 1;
    rd_cycle = s + 1;
    r_rv[(s + 2) % 8] = 1;
  endtask

  always @(negedge clock) begin : monitor
    int  i;
    bit  at, t, idle, free;
    i  = cyc % 8;
    at = 0;
`ifdef TTT_SEQ_AUTO_TICK_EN
    at = (auto_n > 0) && (auto_n % 16 == 0);
`endif
    t = tick_in || at;
    if (armed) begin
      chk("proc_enable",      proc_enable,      r_en[i]);
      chk("proc_instruction", proc_instruction, r_en[i] ? r_op[i] : 4'h0);
      chk("proc_good_tokens", proc_good_tokens, m_good);
      chk("proc_bad_tokens",  proc_bad_tokens,  m_bad);
      chk("proc_data_in",     proc_data_in,     m_din);
      chk("timestep_done",    timestep_done,    r_done[i]);
      chk("tick_overrun",     tick_overrun,     r_over[i]);
      chk("host_rvalid",      host_rvalid,      r_rv[i]);
      chk("host_rdata",       host_rdata,       m_rdata);
      chk("host_ready",       host_ready,       (cyc > last_op) && !t && !pend);
      chk("busy",             busy,             (cyc <= last_op) || pend);
      if (timestep_done === 1'b1) done_cnt++;
    end
    r_en[i] = 0; r_op[i] = 0; r_done[i] = 0; r_over[i] = 0; r_rv[i] = 0;
    if (reset) begin
      armed = 1; last_op = -1; rd_cycle = -1; auto_n = 0; pend = 0;
      pg = 0; pb = 0; m_good = 0; m_bad = 0; m_din = 0; m_rdata = 0;
      for (int k = 0; k < 8; k++) begin
        r_en[k] = 0; r_op[k] = 0; r_done[k] = 0; r_over[k] = 0; r_rv[k] = 0;
      end
    end else if (armed) begin
      auto_n++;
      idle = (cyc > last_op);
      free = idle || (cyc == last_op);
      if (cyc == rd_cycle) m_rdata = proc_data_out;
      if (free && pend) begin
        start_seq(cyc + 1, pg, pb);
        pend = 0;
        if (t) begin pend = 1; pg = good_tokens_in; pb = bad_tokens_in; end
      end else if (idle && t) begin
        start_seq(cyc + 1, good_tokens_in, bad_tokens_in);
      end else if (t) begin
        if (pend) r_over[(cyc + 1) % 8] = 1;
        else begin pend = 1; pg = good_tokens_in; pb = bad_tokens_in; end
      end else if (idle && host_valid) begin
        start_host(cyc + 1);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick(input logic [3:0] g, input logic [3:0] b);
    tick_in = 1; good_tokens_in = g; bad_tokens_in = b;
    step();
    tick_in = 0; good_tokens_in = 0; bad_tokens_in = 0;
  endtask

  task automatic host_cmd(input logic [3:0] op, input logic [7:0] d, output logic [7:0] rd);
    bit ok;
    ok = 0;
    rd = 8'h00;
    for (int n = 0; n < 50; n++) begin
      host_valid = 1; host_instr = op; host_data = d;
      #1;
      if (host_ready) begin ok = 1; break; end
      step();
    end
    chk("host_accept_timeout", ok, 1'b1);
    if (ok) begin
      step();
      host_valid = 0;
      chk("lit_issue_enable", proc_enable, 1'b1);
      chk("lit_issue_opcode", proc_instruction, op);
      chk("lit_ready_busy", host_ready, 1'b0);
      step();
      step();
      chk("lit_rvalid_t3", host_rvalid, 1'b1);
      rd = host_rdata;
    end
    host_valid = 0;
  endtask

  initial begin
    int         t0, acc, d0;
    logic [7:0] rd;
    reset = 1; tick_in = 0; good_tokens_in = 0; bad_tokens_in = 0;
    host_valid = 0; host_instr = 0; host_data = 0;
    repeat (3) step();
    reset = 0;
    repeat (10) step();
    chk("lit_reset_ready", host_ready, 1'b1);
    chk("lit_reset_busy", busy, 1'b0);
    chk("lit_reset_enable", proc_enable, 1'b0);
    chk("lit_reset_tokens", {proc_good_tokens, proc_bad_tokens, proc_data_in}, 16'h0000);

    // one timestep: good=+3, bad=-1
    do_tick(4'h3, 4'hF);
    for (int k = 0; k < 4; k++) begin
      chk("lit_seq_enable", proc_enable, 1'b1);
      chk("lit_seq_opcode", proc_instruction, seq_ops[k]);
      chk("lit_seq_tokens", {proc_good_tokens, proc_bad_tokens}, 8'h3F);
      step();
    end
    chk("lit_seq_done", timestep_done, 1'b1);
    chk("lit_seq_enable_off", proc_enable, 1'b0);
    repeat (3) step();

    host_cmd(4'hE, 8'h05, rd);
    chk("lit_write_rdata", rd, 8'h05);
    host_cmd(4'h7, 8'h00, rd);
    chk("lit_read_rdata", rd, 8'h06);
    repeat (3) step();

    // tick at t, (+1,0) at t+2, dropped tick at t+3
    t0 = cyc; d0 = done_cnt;
    do_tick(4'h2, 4'h5);
    step();
    do_tick(4'h1, 4'h0);
    do_tick(4'h7, 4'h7);
    chk("lit_overrun_t4", tick_overrun, 1'b1);
    step();
    chk("lit_second_start", {proc_enable, proc_instruction, proc_good_tokens, proc_bad_tokens}, 13'h1010);
    chk("lit_second_start_cycle", cyc - t0, 5);
    repeat (8) step();
    chk("lit_two_dones", done_cnt - d0, 2);

    // tick and host request together: tick wins, host accepted on the done cycle
    t0 = cyc; acc = -1;
    tick_in = 1; good_tokens_in = 4'h4; bad_tokens_in = 4'h2;
    host_valid = 1; host_instr = 4'hE; host_data = 8'h3C;
    #1;
    chk("lit_tick_beats_host", host_ready, 1'b0);
    step();
    tick_in = 0; good_tokens_in = 0; bad_tokens_in = 0;
    for (int n = 0; n < 20; n++) begin
      if (host_ready) begin acc = cyc; break; end
      step();
    end
    chk("lit_host_after_done", acc - t0, 5);
    step();
    host_valid = 0;
    repeat (4) step();

    // reset during TALLY aborts the timestep
    do_tick(4'h6, 4'h1);
    step();
    step();
    chk("lit_in_tally", proc_instruction, 4'h8);
    reset = 1;
    step();
    reset = 0;
    chk("lit_abort_enable", proc_enable, 1'b0);
    chk("lit_abort_busy", busy, 1'b0);
    step();
    chk("lit_abort_no_done", timestep_done, 1'b0);
    repeat (3) step();

    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      tick_in        = ($urandom_range(0, 5) == 0);
      good_tokens_in = 4'($urandom);
      bad_tokens_in  = 4'($urandom);
      host_valid     = ($urandom_range(0, 2) == 0);
      host_instr     = 4'($urandom);
      host_data      = 8'($urandom);
      step();
    end
    reset = 0; tick_in = 0; host_valid = 0;
    repeat (10) step();
    chk("final_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
